flag_shadow_stack: RTL
======================

Name: flag_shadow_stack

Overview:
- LIFO of saved flag words that sits directly upstream of the per-flag F registers and feeds their shadow-restore inputs (notShadowF_C and siblings).
- Live flags are pushed on exception entry.
- On exception return (PR_Ex), the top entry is presented in complemented form so the F registers reload it at the same edge as the pop.
- Supports nested exceptions up to DEPTH levels, with sticky overflow/underflow error reporting.

Parameters:
- FLAGS, 8, width of one flag word; bit 0 = C, remaining bits map to the other F registers in fixed order.
- DEPTH, 4, number of stack entries; must be ≥2.
- PTR_W, 3, pointer/count width; must satisfy 2^PTR_W > DEPTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flags  input  FLAGS  current live flag values (F_C at bit 0), sampled on push.
- Ex_Enter  input  1  exception entry strobe; push Flags.
- PR_Ex  input  1  exception return strobe; pop; same signal drives the F-register restore mux.
- Clear_Err  input  1  clears Overflow/Underflow sticky bits.
- notShadowF  output  FLAGS  complement of top-of-stack entry (bit 0 → notShadowF_C).
- Depth  output  PTR_W  number of valid entries, 0..DEPTH.
- Empty  output  1  Depth == 0.
- Full  output  1  Depth == DEPTH.
- Overflow  output  1  sticky: a push was dropped because the stack was full.
- Underflow  output  1  sticky: a pop was attempted on an empty stack.

Behaviour:
- Reset (synchronous, highest priority):
  - all entries ← 0; Depth ← 0; Overflow ← 0; Underflow ← 0.
  - Outputs after the edge: Empty=1, Full=0, notShadowF = all ones.
- notShadowF:
  - Combinational from registered state only: ~entry[Depth-1] when Depth > 0, else all ones.
  - No combinational path from any input.
- Restore timing:
  - While PR_Ex is high, notShadowF holds the pre-edge top.
  - The F registers capture it at the same rising edge that pops it, so restore latency is 0 cycles relative to PR_Ex.
- Push only (Ex_Enter=1, PR_Ex=0):
  - If not Full: entry[Depth] ← Flags; Depth ← Depth+1. notShadowF shows ~Flags from the next cycle.
  - If Full: no entry changes; Depth unchanged; Overflow ← 1.
- Pop only (Ex_Enter=0, PR_Ex=1):
  - If not Empty: Depth ← Depth−1. The popped entry is left stale and is never visible.
  - If Empty: Depth stays 0; Underflow ← 1; notShadowF stays all ones, so restored flags read 0.
- Push and pop in the same cycle (return immediately followed by re-entry):
  - If not Empty: entry[Depth-1] ← Flags; Depth unchanged. The pre-edge top is still delivered to the F registers.
  - If Empty: treated as a push of Flags; Depth ← 1; Underflow ← 1.
  - Never sets Overflow.
- Clear_Err:
  - Clears both sticky bits at the edge.
  - If an error event occurs in the same cycle, the error wins and the bit is set.
- Flags are sampled only at the push edge; changes in other cycles have no effect.
- Reset mid-sequence discards all saved contexts. A PR_Ex in the reset cycle is ignored by this block.
- Invariant: Depth never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset, then idle 3 cycles → Depth=0, Empty=1, Full=0, notShadowF=8'hFF, Overflow=0, Underflow=0.
- Push Flags=8'h01, then push 8'hA5, then PR_Ex for 1 cycle → notShadowF=8'h5A during the PR_Ex cycle; after the edge Depth=1 and notShadowF=8'hFE.
- Push 8'h11, 8'h22, 8'h33, 8'h44 (Full=1), then push 8'h55 → Overflow=1, Depth=4, notShadowF=8'hBB. Pop 4 times → successive notShadowF values BB, CC, DD, EE; then Empty=1.
- From Empty, assert PR_Ex → Underflow=1, Depth=0, notShadowF=8'hFF. Assert Clear_Err → Underflow=0. Assert Clear_Err together with another empty pop → Underflow stays 1.
- With Depth=2 and top=8'h0F, assert Ex_Enter=1 and PR_Ex=1 with Flags=8'hC3 → notShadowF=8'hF0 in that cycle; after the edge Depth=2 and notShadowF=8'h3C.
- With Depth=3, assert Reset together with Ex_Enter → after the edge Depth=0, notShadowF=8'hFF, and no entry is written.

Source files
------------

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: LIFO of saved flag words feeding the F-register
// shadow-restore inputs. Exception entry pushes the live flags, exception
// return pops. The top entry is always presented complemented on notShadowF.
// Overflow and underflow are reported as sticky error bits.
module flag_shadow_stack #(
    parameter int FLAGS = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [FLAGS-1:0] Flags,
    input  logic             Ex_Enter,
    input  logic             PR_Ex,
    input  logic             Clear_Err,
    output logic [FLAGS-1:0] notShadowF,
    output logic [PTR_W-1:0] Depth,
    output logic             Empty,
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] TWO_P   = PTR_W'(2);
    localparam logic [PTR_W-1:0] ZERO_P  = PTR_W'(0);

    logic [FLAGS-1:0] entry_r [DEPTH];
    logic [PTR_W-1:0] depth_r;
    logic [FLAGS-1:0] nsf_r;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;
    logic             unf_r;

    logic             entry_we_s;
    logic [IDX_W-1:0] entry_idx_s;
    logic [PTR_W-1:0] depth_nxt_s;
    logic [PTR_W-1:0] depth_m1_s;
    logic [PTR_W-1:0] depth_m2_s;
    logic [FLAGS-1:0] nsf_nxt_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             is_empty_s;
    logic             is_full_s;

    assign depth_m1_s = depth_r - ONE_P;
    assign depth_m2_s = depth_r - TWO_P;
    assign is_empty_s = (depth_r == ZERO_P);
    assign is_full_s  = (depth_r == DEPTH_P);

    // Next-state decode: which entry to write, new depth, next complemented
    // top-of-stack, and error events for this cycle.
    always_comb begin
        entry_we_s  = 1'b0;
        entry_idx_s = depth_r[IDX_W-1:0];
        depth_nxt_s = depth_r;
        nsf_nxt_s   = nsf_r;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case ({Ex_Enter, PR_Ex})
            2'b10: begin
                if (!is_full_s) begin
                    entry_we_s  = 1'b1;
                    entry_idx_s = depth_r[IDX_W-1:0];
                    depth_nxt_s = depth_r + ONE_P;
                    nsf_nxt_s   = ~Flags;
                end else begin
                    ovf_set_s   = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty_s) begin
                    depth_nxt_s = depth_m1_s;
                    // The popped entry goes stale; expose the one beneath it.
                    if (depth_r >= TWO_P) begin
                        nsf_nxt_s = ~entry_r[depth_m2_s[IDX_W-1:0]];
                    end else begin
                        nsf_nxt_s = {FLAGS{1'b1}};
                    end
                end else begin
                    unf_set_s   = 1'b1;
                end
            end
            2'b11: begin
                // Return followed by immediate re-entry: overwrite the top in
                // place; the pre-edge top is still what the F registers load.
                entry_we_s = 1'b1;
                nsf_nxt_s  = ~Flags;
                if (!is_empty_s) begin
                    entry_idx_s = depth_m1_s[IDX_W-1:0];
                end else begin
                    entry_idx_s = {IDX_W{1'b0}};
                    depth_nxt_s = ONE_P;
                    unf_set_s   = 1'b1;
                end
            end
            default: begin
                entry_we_s = 1'b0;
            end
        endcase
    end

    // Stack storage, depth, sticky errors and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {FLAGS{1'b0}};
            end
            depth_r <= ZERO_P;
            nsf_r   <= {FLAGS{1'b1}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            if (entry_we_s) begin
                entry_r[entry_idx_s] <= Flags;
            end
            depth_r <= depth_nxt_s;
            nsf_r   <= nsf_nxt_s;
            empty_r <= (depth_nxt_s == ZERO_P);
            full_r  <= (depth_nxt_s == DEPTH_P);
            ovf_r   <= ovf_set_s | (ovf_r & ~Clear_Err);
            unf_r   <= unf_set_s | (unf_r & ~Clear_Err);
        end
    end

    assign notShadowF = nsf_r;
    assign Depth      = depth_r;
    assign Empty      = empty_r;
    assign Full       = full_r;
    assign Overflow   = ovf_r;
    assign Underflow  = unf_r;

endmodule
